// File: rtl/spi_register_bridge_pkg.sv
// Shared types and constants for the SPI register bridge and the synth register decode.
package spi_register_bridge_pkg;

    localparam int unsigned SPI_FRAME_BITS = 24;
    localparam int unsigned BIT_COUNT_WIDTH = $clog2(SPI_FRAME_BITS + 1);

    typedef logic [15:0] RegisterNumber_t;
    typedef logic [7:0]  RegisterValue_t;

    // Top two bits of a register number select its scope.
    localparam logic [1:0] SCOPE_VOICE_OP = 2'b11;
    localparam logic [1:0] SCOPE_VOICE    = 2'b10;
    localparam logic [1:0] SCOPE_GLOBAL   = 2'b01;

    typedef enum logic {
        StIdle,
        StShift
    } BridgeState_t;

endpackage

// File: rtl/spi_register_bridge_input_synchronizer.sv
// Multi-flop synchronizer for one asynchronous input, with a configurable reset value.
module spi_register_bridge_input_synchronizer #(
    parameter int unsigned STAGES      = 2,
    parameter logic        RESET_VALUE = 1'b0
) (
    input  logic i_Clock,
    input  logic i_Reset,
    input  logic i_Async,
    output logic o_Sync
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            chain <= {STAGES{RESET_VALUE}};
        end else begin
            chain <= {chain[STAGES-2:0], i_Async};
        end
    end

    assign o_Sync = chain[STAGES-1];

endmodule

// File: rtl/spi_register_bridge.sv
// SPI mode-0 slave turning 24-bit host frames into register-write strobes.
// Build with SPI_REGISTER_READBACK_EN to shift the previous frame back out on MISO.
module spi_register_bridge
    import spi_register_bridge_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned FRAME_BITS  = SPI_FRAME_BITS
) (
    input  logic        i_Clock,
    input  logic        i_Reset,
    input  logic        i_SPI_SCK,
    input  logic        i_SPI_CS_N,
    input  logic        i_SPI_MOSI,
    output logic        o_SPI_MISO,
    output logic        o_RegisterWriteEnable,
    output logic [15:0] o_RegisterWriteNumber,
    output logic [7:0]  o_RegisterWriteValue,
    output logic        o_FrameError
);

    if (FRAME_BITS != SPI_FRAME_BITS) begin : g_bad_frame_bits
        $error("spi_register_bridge: FRAME_BITS must be 24");
    end
    if (SYNC_STAGES < 2) begin : g_bad_sync_stages
        $error("spi_register_bridge: SYNC_STAGES must be at least 2");
    end

    localparam logic [BIT_COUNT_WIDTH-1:0] FRAME_COUNT = BIT_COUNT_WIDTH'(FRAME_BITS);
    localparam int unsigned SETTLE_WIDTH = $clog2(SYNC_STAGES + 1);

    logic sck_sync, cs_n_sync, mosi_sync;
    logic sck_prev, cs_n_prev;
    logic sck_rise, cs_rise, cs_fall;
    logic sck_take;
    logic [BIT_COUNT_WIDTH-1:0] bit_count, count_after;
    logic [FRAME_BITS-1:0] shift_reg;
    logic [SETTLE_WIDTH-1:0] settle_count;
    logic armed;
    BridgeState_t state;

    spi_register_bridge_input_synchronizer #(
        .STAGES     (SYNC_STAGES),
        .RESET_VALUE(1'b0)
    ) u_sync_sck (
        .i_Clock(i_Clock),
        .i_Reset(i_Reset),
        .i_Async(i_SPI_SCK),
        .o_Sync (sck_sync)
    );

    spi_register_bridge_input_synchronizer #(
        .STAGES     (SYNC_STAGES),
        .RESET_VALUE(1'b1)
    ) u_sync_cs_n (
        .i_Clock(i_Clock),
        .i_Reset(i_Reset),
        .i_Async(i_SPI_CS_N),
        .o_Sync (cs_n_sync)
    );

    spi_register_bridge_input_synchronizer #(
        .STAGES     (SYNC_STAGES),
        .RESET_VALUE(1'b0)
    ) u_sync_mosi (
        .i_Clock(i_Clock),
        .i_Reset(i_Reset),
        .i_Async(i_SPI_MOSI),
        .o_Sync (mosi_sync)
    );

    assign sck_rise = sck_sync & ~sck_prev;
    assign cs_rise  = cs_n_sync & ~cs_n_prev;
    assign cs_fall  = ~cs_n_sync & cs_n_prev;

    always_comb begin
        sck_take    = (state == StShift) && sck_rise && (bit_count != FRAME_COUNT);
        count_after = sck_take ? bit_count + BIT_COUNT_WIDTH'(1) : bit_count;
    end

`ifdef SPI_REGISTER_READBACK_EN
    logic sck_fall;
    logic [FRAME_BITS-1:0] shadow, tx_shift;
    assign sck_fall   = ~sck_sync & sck_prev;
    assign o_SPI_MISO = tx_shift[FRAME_BITS-1];
`else
    assign o_SPI_MISO = 1'b0;
`endif

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            sck_prev              <= 1'b0;
            cs_n_prev             <= 1'b1;
            state                 <= StIdle;
            bit_count             <= '0;
            shift_reg             <= '0;
            settle_count          <= SETTLE_WIDTH'(SYNC_STAGES);
            armed                 <= 1'b0;
            o_RegisterWriteEnable <= 1'b0;
            o_RegisterWriteNumber <= '0;
            o_RegisterWriteValue  <= '0;
            o_FrameError          <= 1'b0;
`ifdef SPI_REGISTER_READBACK_EN
            shadow                <= '0;
            tx_shift              <= '0;
`endif
        end else begin
            sck_prev              <= sck_sync;
            cs_n_prev             <= cs_n_sync;
            o_RegisterWriteEnable <= 1'b0;
            o_FrameError          <= 1'b0;

            // The chain holds preset values for SYNC_STAGES cycles after reset; only arm once
            // CS_N has really been seen high, so a select held low through reset cannot start
            // a frame.
            if (settle_count != '0) begin
                settle_count <= settle_count - SETTLE_WIDTH'(1);
            end else if (cs_n_sync) begin
                armed <= 1'b1;
            end

            if (bit_count == FRAME_COUNT) begin
                o_RegisterWriteEnable <= 1'b1;
                o_RegisterWriteNumber <= shift_reg[FRAME_BITS-1:8];
                o_RegisterWriteValue  <= shift_reg[7:0];
                bit_count             <= '0;
`ifdef SPI_REGISTER_READBACK_EN
                shadow                <= shift_reg;
`endif
            end

            unique case (state)
                StIdle: begin
                    if (armed && cs_fall) begin
                        state     <= StShift;
                        bit_count <= '0;
`ifdef SPI_REGISTER_READBACK_EN
                        tx_shift  <= (bit_count == FRAME_COUNT) ? shift_reg : shadow;
`endif
                    end
                end
                StShift: begin
                    if (sck_take) begin
                        shift_reg <= {shift_reg[FRAME_BITS-2:0], mosi_sync};
                        bit_count <= count_after;
                    end
`ifdef SPI_REGISTER_READBACK_EN
                    if (sck_fall) begin
                        tx_shift <= {tx_shift[FRAME_BITS-2:0], 1'b0};
                    end
`endif
                    // A rise landing with the CS_N rise is counted first, so a completing
                    // frame still writes from IDLE on the following cycle.
                    if (cs_rise) begin
                        state <= StIdle;
                        if (count_after != '0 && count_after != FRAME_COUNT) begin
                            o_FrameError <= 1'b1;
                            bit_count    <= '0;
                        end
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_register_bridge.sv
// Randomized scoreboard bench for spi_register_bridge; honours SPI_REGISTER_READBACK_EN.
`timescale 1ns/1ps
module tb_spi_register_bridge;

    localparam int SyncStages = 2;
    localparam int HalfCycles = 6;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic sck = 1'b0;
    logic cs_n = 1'b1;
    logic mosi = 1'b0;
    logic miso, we, fe;
    logic [15:0] number;
    logic [7:0] value;

    always #5 clk = ~clk;

    spi_register_bridge #(
        .SYNC_STAGES(SyncStages),
        .FRAME_BITS (24)
    ) dut (
        .i_Clock              (clk),
        .i_Reset              (rst),
        .i_SPI_SCK            (sck),
        .i_SPI_CS_N           (cs_n),
        .i_SPI_MOSI           (mosi),
        .o_SPI_MISO           (miso),
        .o_RegisterWriteEnable(we),
        .o_RegisterWriteNumber(number),
        .o_RegisterWriteValue (value),
        .o_FrameError         (fe)
    );

    typedef struct {
        bit          is_error;
        logic [15:0] number;
        logic [7:0]  value;
        int          rise_cycle;
    } expect_t;

    expect_t exp_q[$];
    int checks = 0;
    int errors = 0;
    int cycle = 0;

    // Reference model state: what a host-side observer knows about the link.
    bit          in_frame = 1'b0;
    int          frame_bits = 0;
    int          window_bits = 0;
    logic [23:0] acc = '0;
    logic [23:0] shadow = '0;
    logic [23:0] tx_expect = '0;
    logic [15:0] last_number = '0;
    logic [7:0]  last_value = '0;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] required);
        checks++;
        if (actual !== required) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h at cycle %0d", name, actual, required,
                     cycle);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic handle_event(input bit got_error);
        expect_t e;
        if (exp_q.size() == 0) begin
            check(got_error ? "unexpected_frame_error" : "unexpected_write", 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            check("event_kind", 32'(got_error), 32'(e.is_error));
            if (!got_error && !e.is_error) begin
                check("write_number", 32'(number), 32'(e.number));
                check("write_value", 32'(value), 32'(e.value));
                check("write_latency", 32'(cycle - e.rise_cycle), 32'(SyncStages + 2));
            end
        end
    endtask

    task automatic monitor();
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (we) handle_event(1'b0);
                if (fe) handle_event(1'b1);
            end
        end
    endtask

    task automatic send_bit(input logic b);
        expect_t e;
        @(negedge clk);
        mosi = b;
        wait_cycles(HalfCycles);
`ifdef SPI_REGISTER_READBACK_EN
        if (in_frame && window_bits < 24) begin
            check("miso_readback", 32'(miso), 32'(tx_expect[23 - window_bits]));
        end
`else
        check("miso_constant_zero", 32'(miso), 32'd0);
`endif
        sck = 1'b1;
        if (in_frame) begin
            acc = {acc[22:0], b};
            frame_bits++;
            window_bits++;
            if (frame_bits == 24) begin
                e.is_error   = 1'b0;
                e.number     = acc[23:8];
                e.value      = acc[7:0];
                e.rise_cycle = cycle;
                exp_q.push_back(e);
                shadow      = acc;
                last_number = acc[23:8];
                last_value  = acc[7:0];
                frame_bits  = 0;
            end
        end
        wait_cycles(HalfCycles);
        sck = 1'b0;
    endtask

    task automatic send_bits(input logic [23:0] data, input int nbits);
        for (int i = 0; i < nbits; i++) send_bit(data[23 - i]);
    endtask

    task automatic cs_low();
        @(negedge clk);
        cs_n        = 1'b0;
        in_frame    = 1'b1;
        frame_bits  = 0;
        window_bits = 0;
        tx_expect   = shadow;
        wait_cycles(8);
    endtask

    task automatic cs_high();
        expect_t e;
        wait_cycles(4);
        cs_n = 1'b1;
        if (in_frame && frame_bits != 0) begin
            e.is_error   = 1'b1;
            e.number     = '0;
            e.value      = '0;
            e.rise_cycle = cycle;
            exp_q.push_back(e);
        end
        in_frame   = 1'b0;
        frame_bits = 0;
        wait_cycles(12);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst = 1'b1;
        wait_cycles(3);
        check("reset_write_enable", 32'(we), 32'd0);
        check("reset_number", 32'(number), 32'd0);
        check("reset_value", 32'(value), 32'd0);
        check("reset_frame_error", 32'(fe), 32'd0);
        check("reset_miso", 32'(miso), 32'd0);
        rst         = 1'b0;
        in_frame    = 1'b0;
        frame_bits  = 0;
        shadow      = '0;
        last_number = '0;
        last_value  = '0;
    endtask

    task automatic watchdog();
        #600000;
        $display("FAIL watchdog actual=timeout required=finish at cycle %0d", cycle);
        $fatal(1, "watchdog expired");
    endtask

    initial begin
        logic [23:0] data;
        int nframes;
        fork
            monitor();
            watchdog();
        join_none

        pulse_reset();
        wait_cycles(10);

        // Single frame.
        cs_low();
        send_bits(24'hC4053A, 24);
        cs_high();

        // Burst of two frames in one select window.
        cs_low();
        send_bits(24'h400001, 24);
        send_bits(24'hC00080, 24);
        cs_high();
        check("hold_number_after_burst", 32'(number), 32'h0000C000);
        check("hold_value_after_burst", 32'(value), 32'h00000080);

        // Partial frame, then a clean one.
        cs_low();
        send_bits(24'($urandom()), 13);
        cs_high();
        cs_low();
        send_bits(24'hC100FF, 24);
        cs_high();

        // Reset mid-frame with select held low; further bits must be ignored.
        cs_low();
        send_bits(24'($urandom()), 10);
        pulse_reset();
        send_bits(24'($urandom()), 14);
        cs_high();
        cs_low();
        send_bits(24'($urandom()), 24);
        cs_high();

        // Clock activity with select high, then a frame to prove the counter stayed at zero.
        for (int i = 0; i < 15; i++) send_bit(1'($urandom()));
        wait_cycles(10);
        cs_low();
        send_bits(24'h2A1234, 24);
        cs_high();

        // Readback source followed by an all-zero frame.
        cs_low();
        send_bits(24'hC40B7F, 24);
        cs_high();
        cs_low();
        send_bits(24'h000000, 24);
        cs_high();

        // Random bursts with optional trailing partial frames.
        for (int t = 0; t < 6; t++) begin
            cs_low();
            nframes = $urandom_range(1, 3);
            for (int f = 0; f < nframes; f++) begin
                data = 24'($urandom());
                send_bits(data, 24);
            end
            if ($urandom_range(0, 1) == 1) send_bits(24'($urandom()), $urandom_range(1, 23));
            cs_high();
        end

        wait_cycles(40);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        check("final_hold_number", 32'(number), 32'(last_number));
        check("final_hold_value", 32'(value), 32'(last_value));
        check("final_idle_strobe", 32'(we), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
